// File: rtl/elastic_buffer_skp_ctrl.sv
// Clock-compensation controller for the receive elastic buffer.
// Tracks fill level and requests one SKP add/delete per SKP ordered set.
module elastic_buffer_skp_ctrl #(
  parameter int                    DATA_WIDTH   = 10,
  parameter int                    BUFFER_DEPTH = 16,
  parameter int                    HIGH_TH      = 10,
  parameter int                    LOW_TH       = 6,
  parameter logic [DATA_WIDTH-1:0] COM_N        = 10'b0011111010,
  parameter logic [DATA_WIDTH-1:0] COM_P        = 10'b1100000101,
  parameter logic [DATA_WIDTH-1:0] SKP_N        = 10'b0011110100,
  parameter logic [DATA_WIDTH-1:0] SKP_P        = 10'b1100001011,
  localparam int                   ADDR         = $clog2(BUFFER_DEPTH)
) (
  input  logic                  read_clk,
  input  logic                  rst,
  input  logic [ADDR:0]         gray_write_pointer,
  input  logic [ADDR:0]         gray_read_pointer,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  add_req,
  output logic                  delete_req,
  output logic [ADDR:0]         fill_level,
  output logic                  skp_added,
  output logic                  skp_deleted,
  output logic                  ovf_err
);

  localparam int             AW       = ADDR + 1;
  localparam logic [ADDR:0]  LOW_LVL  = AW'(LOW_TH);
  localparam logic [ADDR:0]  HIGH_LVL = AW'(HIGH_TH);
  localparam logic [ADDR:0]  FULL_LVL = AW'(BUFFER_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COM,
    S_ADJ,
    S_WAIT_END
  } state_t;

  state_t        state_q, state_d;
  logic [ADDR:0] fill_q, fill_d;
  logic          add_q, add_d;
  logic          del_q, del_d;
  logic          ovf_q, ovf_d;

  logic [ADDR:0] wr_bin, rd_bin;
  logic          is_com, is_skp;
  logic          fill_low, fill_high;

  function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
    logic [ADDR:0] b;
    b[ADDR] = g[ADDR];
    for (int i = ADDR - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wr_bin = gray2bin(gray_write_pointer);
  assign rd_bin = gray2bin(gray_read_pointer);

  // Modular subtraction on ADDR+1 bits covers pointer wrap for free.
  assign fill_d = wr_bin - rd_bin;
  assign ovf_d  = ovf_q | (fill_q == FULL_LVL);

  assign is_com = !empty && ((data_out == COM_N) || (data_out == COM_P));
  assign is_skp = !empty && ((data_out == SKP_N) || (data_out == SKP_P));

  // Decisions use the registered (one cycle old) level; thresholds absorb it.
  assign fill_low  = (fill_q < LOW_LVL);
  assign fill_high = (fill_q > HIGH_LVL);

  always_comb begin
    state_d = state_q;
    add_d   = 1'b0;
    del_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_com) state_d = S_COM;
      end
      S_COM: begin
        if (empty) begin
          state_d = S_COM;
        end else if (is_skp) begin
          state_d = S_ADJ;
          add_d   = fill_low;
          del_d   = fill_high && !fill_low;
        end else if (is_com) begin
          state_d = S_COM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADJ: begin
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (is_skp || empty) begin
          state_d = S_WAIT_END;
        end else if (is_com) begin
          state_d = S_COM;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      add_q   <= 1'b0;
      del_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      add_q   <= add_d;
      del_q   <= del_d;
      ovf_q   <= ovf_d;
    end
  end

  assign add_req     = add_q;
  assign skp_added   = add_q;
  assign delete_req  = del_q;
  assign skp_deleted = del_q;
  assign fill_level  = fill_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_elastic_buffer_skp_ctrl.sv
// Self-checking bench for elastic_buffer_skp_ctrl: directed steps plus random
// traffic, compared each cycle against a history-based reference model.
module tb_elastic_buffer_skp_ctrl;

  localparam int         DEPTH  = 16;
  localparam int         LOW_TH = 6;
  localparam int         HIGH_TH = 10;
  localparam logic [9:0] COM_N  = 10'b0011111010;
  localparam logic [9:0] COM_P  = 10'b1100000101;
  localparam logic [9:0] SKP_N  = 10'b0011110100;
  localparam logic [9:0] SKP_P  = 10'b1100001011;
  localparam logic [9:0] D21_5  = 10'b1010101010;
  localparam logic [9:0] D_SYM  = 10'b1001110100;

  logic       read_clk = 1'b0;
  logic       rst;
  logic [4:0] gray_write_pointer;
  logic [4:0] gray_read_pointer;
  logic       empty;
  logic [9:0] data_out;
  logic       add_req, delete_req, skp_added, skp_deleted, ovf_err;
  logic [4:0] fill_level;

  elastic_buffer_skp_ctrl dut (
    .read_clk           (read_clk),
    .rst                (rst),
    .gray_write_pointer (gray_write_pointer),
    .gray_read_pointer  (gray_read_pointer),
    .empty              (empty),
    .data_out           (data_out),
    .add_req            (add_req),
    .delete_req         (delete_req),
    .fill_level         (fill_level),
    .skp_added          (skp_added),
    .skp_deleted        (skp_deleted),
    .ovf_err            (ovf_err)
  );

  always #5 read_clk = ~read_clk;

  // One record per clock cycle: what the symbol stream looked like and
  // whether that cycle was the first-SKP decision point.
  typedef struct packed {
    bit rst;
    bit valid;
    bit com;
    bit skp;
    bit dec;
  } cyc_t;

  cyc_t       hist[$];
  logic [4:0] m_fill = '0;
  logic       m_ovf  = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         obs_add = 0;
  int         obs_del = 0;
  logic [4:0] cur_wb = '0;
  logic [4:0] cur_rb = '0;

  // A valid SKP triggers a decision when the most recent valid symbol before
  // it (looking past empty cycles, stopping at reset) is a COM that was not
  // swallowed by the cycle right after a previous decision.
  function automatic bit decide(input cyc_t c);
    int n;
    n = hist.size();
    if (c.rst || !c.skp) return 1'b0;
    if (n > 0 && hist[n-1].dec) return 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (hist[i].rst) return 1'b0;
      if (hist[i].valid) return hist[i].com && !(i > 0 && hist[i-1].dec);
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input logic [4:0] wb, input logic [4:0] rb,
                      input bit e, input logic [9:0] d);
    cyc_t c;
    bit   exp_add, exp_del;
    rst                = r;
    gray_write_pointer = wb ^ (wb >> 1);
    gray_read_pointer  = rb ^ (rb >> 1);
    empty              = e;
    data_out           = d;
    c.rst   = r;
    c.valid = !e;
    c.com   = !e && (d == COM_N || d == COM_P);
    c.skp   = !e && (d == SKP_N || d == SKP_P);
    c.dec   = decide(c);
    exp_add = c.dec && (int'(m_fill) < LOW_TH);
    exp_del = c.dec && (int'(m_fill) > HIGH_TH);
    hist.push_back(c);
    @(posedge read_clk);
    #1;
    m_ovf  = r ? 1'b0 : (m_ovf | (int'(m_fill) == DEPTH));
    m_fill = r ? 5'd0 : 5'(wb - rb);
    if (add_req === 1'b1) obs_add++;
    if (delete_req === 1'b1) obs_del++;
    chk("fill_level", 32'(fill_level), 32'(m_fill));
    chk("add_req", 32'(add_req), 32'(exp_add));
    chk("delete_req", 32'(delete_req), 32'(exp_del));
    chk("skp_added", 32'(skp_added), 32'(exp_add));
    chk("skp_deleted", 32'(skp_deleted), 32'(exp_del));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
  endtask

  task automatic set_fill(input int f);
    cur_rb = 5'($urandom_range(0, 31));
    cur_wb = 5'(cur_rb + 5'(f));
  endtask

  task automatic sym(input logic [9:0] d);
    step(1'b0, cur_wb, cur_rb, 1'b0, d);
  endtask

  task automatic gap();
    step(1'b0, cur_wb, cur_rb, 1'b1, 10'($urandom));
  endtask

  task automatic skp_set(input logic [9:0] com, input logic [9:0] skp);
    sym(com); sym(skp); sym(skp); sym(skp); sym(D_SYM);
  endtask

  task automatic settle();
    sym(D_SYM); sym(D_SYM);
  endtask

  function automatic logic [9:0] rand_sym();
    int k;
    logic [9:0] d;
    k = $urandom_range(0, 9);
    if (k == 0) return COM_N;
    if (k == 1) return COM_P;
    if (k <= 3) return SKP_N;
    if (k <= 5) return SKP_P;
    d = 10'($urandom);
    if (d == COM_N || d == COM_P || d == SKP_N || d == SKP_P) d = D21_5;
    return d;
  endfunction

  int a0, d0;

  initial begin
    // Reset with random inputs, then release with both pointers at zero.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 10'($urandom));
    cur_wb = '0; cur_rb = '0;
    for (int i = 0; i < 3; i++) sym(D_SYM);
    chk("fill_after_reset", 32'(fill_level), 32'd0);

    // Low fill: exactly one add.
    set_fill(4); settle();
    a0 = obs_add; d0 = obs_del;
    skp_set(COM_N, SKP_N);
    chk("low_add_count", 32'(obs_add - a0), 32'd1);
    chk("low_del_count", 32'(obs_del - d0), 32'd0);

    // High fill: exactly one delete.
    set_fill(12); settle();
    a0 = obs_add; d0 = obs_del;
    skp_set(COM_P, SKP_P);
    chk("high_del_count", 32'(obs_del - d0), 32'd1);
    chk("high_add_count", 32'(obs_add - a0), 32'd0);

    // Thresholds and nominal: no requests.
    a0 = obs_add; d0 = obs_del;
    set_fill(6);  settle(); skp_set(COM_N, SKP_N);
    set_fill(8);  settle(); skp_set(COM_P, SKP_N);
    set_fill(10); settle(); skp_set(COM_N, SKP_P);
    chk("threshold_req_count", 32'(obs_add + obs_del - a0 - d0), 32'd0);

    // COM followed by a data symbol abandons the set.
    set_fill(3); settle();
    a0 = obs_add;
    sym(COM_N); sym(D21_5); sym(SKP_N); sym(SKP_N); sym(D_SYM);
    chk("com_data_no_req", 32'(obs_add - a0), 32'd0);

    // Pointer wrap-around.
    cur_wb = 5'b00010; cur_rb = 5'b11110;
    settle();
    chk("wrap_fill", 32'(fill_level), 32'd4);

    // Back-to-back sets, one add each.
    set_fill(4); settle();
    a0 = obs_add;
    sym(COM_N); sym(SKP_N); sym(SKP_N);
    sym(COM_P); sym(SKP_P); sym(SKP_P); sym(D_SYM);
    chk("b2b_add_count", 32'(obs_add - a0), 32'd2);

    // Empty cycles between COM and the first SKP delay the decision.
    a0 = obs_add;
    sym(COM_N); gap(); gap(); sym(SKP_N); sym(SKP_N); gap(); sym(SKP_N); sym(D_SYM);
    chk("empty_add_count", 32'(obs_add - a0), 32'd1);

    // Reset in the decision cycle, and reset in the pulse cycle.
    a0 = obs_add;
    sym(COM_N); step(1'b1, cur_wb, cur_rb, 1'b0, SKP_N); sym(SKP_N); sym(D_SYM);
    chk("rst_decision_no_add", 32'(obs_add - a0), 32'd0);
    settle();
    sym(COM_N); sym(SKP_N); step(1'b1, cur_wb, cur_rb, 1'b0, SKP_N);
    sym(SKP_N); sym(D_SYM);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) set_fill($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0)
        step(1'b1, cur_wb, cur_rb, 1'b0, rand_sym());
      else if ($urandom_range(0, 7) == 0)
        gap();
      else
        sym(rand_sym());
    end

    // Full buffer: overflow sets and stays until reset.
    cur_rb = 5'd7; cur_wb = 5'd23;
    settle(); sym(D_SYM);
    chk("full_fill", 32'(fill_level), 32'd16);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    set_fill(4); settle(); skp_set(COM_N, SKP_N);
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
    step(1'b1, cur_wb, cur_rb, 1'b0, D_SYM);
    chk("ovf_cleared", 32'(ovf_err), 32'd0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elastic_buffer_skp_ctrl.md
# elastic_buffer_skp_ctrl

Clock-compensation controller for the receive elastic buffer. It runs in the read (recovered-to-local) clock domain and computes the buffer fill level from the synchronized write pointer and the local read pointer. It watches the symbol stream leaving the buffer for SKP ordered sets (COM followed by SKPs). At the first SKP of each ordered set it issues at most one `add_req` or one `delete_req` to the read pointer control, so the fill level stays near half depth.

## Interface
- DATA_WIDTH, 10, symbol width (10b encoded)
- BUFFER_DEPTH, 16, elastic buffer entries (power of two); ADDR = $clog2(BUFFER_DEPTH)
- HIGH_TH, 10, fill level above which a SKP is deleted
- LOW_TH, 6, fill level below which a SKP is added
- COM_N / COM_P, 10'b0011111010 / 10'b1100000101, K28.5 RD-/RD+
- SKP_N / SKP_P, 10'b0011110100 / 10'b1100001011, K28.0 RD-/RD+

Ports:
- read_clk  in  1  the block's only clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- gray_write_pointer  in  ADDR+1  Gray write pointer, already 2-FF synchronized into read_clk
- gray_read_pointer  in  ADDR+1  Gray read pointer from read pointer control
- empty  in  1  buffer empty flag from read pointer control; data_out invalid when 1
- data_out  in  DATA_WIDTH  symbol currently presented at buffer output
- add_req  out  1  one-cycle pulse; read pointer holds one cycle, so the current SKP repeats
- delete_req  out  1  one-cycle pulse; read pointer advances by 2, so the next SKP is skipped
- fill_level  out  ADDR+1  registered occupancy, 0..BUFFER_DEPTH
- skp_added  out  1  one-cycle pulse, coincident with add_req
- skp_deleted  out  1  one-cycle pulse, coincident with delete_req
- ovf_err  out  1  sticky; set when fill_level == BUFFER_DEPTH; cleared only by rst

## Operation
- Each cycle, Gray-to-binary convert both pointers. Compute `fill_level <= wr_bin - rd_bin` modulo 2^(ADDR+1), so pointer wrap is handled without special cases.
- is_com = data_out ∈ {COM_N, COM_P}; is_skp = data_out ∈ {SKP_N, SKP_P}. Both are forced to 0 while empty=1.
- FSM states are IDLE, COM, ADJ and WAIT_END.
- IDLE: is_com → COM; otherwise stay.
- COM: empty=1 → stay. is_skp → ADJ. is_com → stay in COM (a repeated COM restarts the set). Any other symbol → IDLE, with no request.
- On the COM→ADJ transition, register:
  - add_req <= (fill_level < LOW_TH)
  - delete_req <= (fill_level > HIGH_TH) && !(fill_level < LOW_TH)
  - add_req and delete_req are never both 1.
- ADJ lasts exactly one cycle and is the cycle in which any request pulse is high. It always goes to WAIT_END.
- WAIT_END: is_skp or empty=1 → stay. is_com → COM. Any other symbol → IDLE.
- At most one adjustment per ordered set. No second decision is taken until a new COM is seen.
- Decisions use the registered fill_level, which is one cycle stale. This is intended, and the thresholds absorb it.
- ovf_err sets on any cycle where fill_level == BUFFER_DEPTH.

## Timing
- Reset values (rst=1 sampled at a rising edge): state=IDLE; add_req, delete_req, skp_added, skp_deleted and ovf_err all 0; fill_level=0.
- rst asserted mid-ordered-set (including in ADJ) drops every pulse the next cycle. It also abandons the set: no request is issued for it.
- Pointer to fill_level latency is 1 cycle.
- First SKP at data_out (cycle N) → add_req/delete_req high in cycle N+1 only, together with skp_added/skp_deleted.
- Read pointer control acts in cycle N+1.
- A set of COM + 1 SKP can still receive an add. Delete in that case is the buffer's responsibility. The controller does not inspect symbols beyond the first SKP.
- fill_level == LOW_TH or == HIGH_TH exactly → no request (strict compares).

## Test plan
- Reset: hold rst 3 cycles with random inputs → all outputs 0, state IDLE. Release with wr=rd Gray 0 → fill_level stays 0.
- Low fill add: fill_level=4, stream COM_N, SKP_N, SKP_N, SKP_N, D-symbol → exactly one add_req/skp_added pulse, in the cycle after the first SKP; no delete_req.
- High fill delete: fill_level=12, stream COM_P, SKP_P×3 → exactly one delete_req/skp_deleted pulse, 1 cycle after the first SKP.
- Threshold and nominal: fill_level=6, 8 and 10 with the same SKP set → no requests. Non-SKP after COM (COM, D21.5) at fill=3 → no request, FSM returns to IDLE.
- Wrap-around: binary write pointer 5'b00010 and read pointer 5'b11110 (Gray-encoded) → fill_level=4. Write pointer = read pointer + 16 → fill_level=16 and ovf_err set and sticky until rst.
- Back-to-back and empty: two consecutive SKP sets at fill=4 → one add per set. empty=1 inserted between COM and the first SKP → the decision is delayed until the SKP is valid, and there is still exactly one pulse.
